// File: rtl/dds_rate_checker.sv
// dds_rate_checker: qualifies a single-cycle enable strobe stream produced by
// a fractional DDS rate source. Checks ADD_NUM strobes per MAX_NUM-clock window
// and strobe spacing within [floor(MAX/ADD), ceil(MAX/ADD)] clocks. Reports
// lock, one-cycle error pulses and a saturating error count.
module dds_rate_checker #(
  parameter int unsigned             COUNT_WIDTH  = 4,
  parameter logic [COUNT_WIDTH-1:0]  ADD_NUM      = 4'd3,
  parameter logic [COUNT_WIDTH-1:0]  MAX_NUM      = 4'd5,
  parameter int unsigned             LOCK_WINDOWS = 4
) (
  input  logic                   clk,
  input  logic                   rst,        // asynchronous, active-low
  input  logic                   enable,
  input  logic                   clr,
  output logic                   locked,
  output logic                   err,
  output logic [7:0]             err_count,
  output logic [COUNT_WIDTH-1:0] last_cnt
);

  // Gap counter is one bit wider than the window counters so that GMAX+1 is
  // always representable and the counter can saturate above it.
  localparam int unsigned DW = COUNT_WIDTH + 1;
  localparam int unsigned GW = $clog2(LOCK_WINDOWS + 1);

  localparam logic [DW-1:0] GMIN = DW'(MAX_NUM / ADD_NUM);
  localparam logic [DW-1:0] GMAX = GMIN + DW'((MAX_NUM % ADD_NUM) != '0);

  localparam logic [COUNT_WIDTH-1:0] WPOS_LAST = MAX_NUM - COUNT_WIDTH'(1);
  localparam logic [GW-1:0]          LOCK_N    = GW'(LOCK_WINDOWS);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_TRACK,
    S_LOCKED
  } state_t;

  state_t                 r_state;
  logic [COUNT_WIDTH-1:0] r_wpos;
  logic [COUNT_WIDTH-1:0] r_wcnt;
  logic [DW-1:0]          r_dist;
  logic [GW-1:0]          r_good;
  logic                   r_locked;
  logic                   r_err;
  logic [7:0]             r_err_count;
  logic [COUNT_WIDTH-1:0] r_last_cnt;

  logic                   w_tracking;
  logic                   w_active;
  logic [COUNT_WIDTH-1:0] w_pos_cur;
  logic [COUNT_WIDTH-1:0] w_cnt_final;
  logic                   w_win_end;
  logic                   w_win_good;
  logic                   w_gap_short;
  logic                   w_gap_long;
  logic                   w_viol;
  logic [DW-1:0]          w_dist_inc;
  logic [7:0]             w_err_inc;
  logic [GW-1:0]          w_good_inc;

  // Current-cycle window/gap evaluation. The alignment cycle in SEARCH is
  // treated as window position 0 with an empty prior count.
  always_comb begin
    // NOTE: every signal is assigned on every path of this block, so no
    // latch can be inferred; keep it that way when adding terms.
    w_tracking  = (r_state != S_SEARCH);
    w_active    = w_tracking || enable;
    w_pos_cur   = w_tracking ? r_wpos : '0;
    w_cnt_final = (w_tracking ? r_wcnt : '0) + COUNT_WIDTH'(enable);
    w_win_end   = w_active && (w_pos_cur == WPOS_LAST);
    w_win_good  = (w_cnt_final == ADD_NUM);
    // Gap checks need a previous strobe, so they only run once aligned.
    w_gap_short = w_tracking && enable && (r_dist < GMIN);
    w_gap_long  = w_tracking && (r_dist > GMAX);
    w_viol      = w_gap_short || w_gap_long ||
                  (w_tracking && w_win_end && !w_win_good);
    w_dist_inc  = (r_dist == '1) ? r_dist : r_dist + DW'(1);
    w_err_inc   = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;
    w_good_inc  = r_good + GW'(1);
  end

  // FSM, window/gap counters and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    if (!rst) begin
      r_state     <= S_SEARCH;
      r_wpos      <= '0;
      r_wcnt      <= '0;
      r_dist      <= '0;
      r_good      <= '0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
      r_last_cnt  <= '0;
    end else begin
      r_err <= 1'b0;

      if (w_win_end) begin
        r_last_cnt <= w_cnt_final;
      end

      if (clr || w_viol) begin
        // Drop back to SEARCH; a strobe on this cycle is not reused for
        // realignment. clr suppresses the error report of a coincident violation.
        r_state  <= S_SEARCH;
        r_locked <= 1'b0;
        r_wpos   <= '0;
        r_wcnt   <= '0;
        r_dist   <= '0;
        r_good   <= '0;
        if (clr) begin
          r_err_count <= '0;
        end else begin
          r_err       <= 1'b1;
          r_err_count <= w_err_inc;
        end
      end else if (w_active) begin
        r_wpos <= w_win_end ? '0 : w_pos_cur + COUNT_WIDTH'(1);
        r_wcnt <= w_win_end ? '0 : w_cnt_final;
        r_dist <= enable ? DW'(1) : w_dist_inc;

        if (w_win_end && w_win_good && (r_state != S_LOCKED)) begin
          if (w_good_inc == LOCK_N) begin
            r_state  <= S_LOCKED;
            r_locked <= 1'b1;
            r_good   <= '0;
          end else begin
            r_state <= S_TRACK;
            r_good  <= w_good_inc;
          end
        end else if (r_state == S_SEARCH) begin
          r_state <= S_TRACK;
        end
      end
    end
  end

  assign locked    = r_locked;
  assign err       = r_err;
  assign err_count = r_err_count;
  assign last_cnt  = r_last_cnt;

endmodule

// File: doc/dds_rate_checker.md
Name: dds_rate_checker

Overview:
- Receive-side companion to the fractional DDS enable generator.
- Monitors a single-cycle `enable` strobe stream. Checks that the stream carries exactly ADD_NUM strobes in every MAX_NUM-clock window and that strobe spacing stays within the ideal DDS jitter bounds.
- Reports lock status, error pulses and a saturating error count.
- Sits downstream of a DDS rate source, or at a clock-domain-local rate input, to qualify that source before consumers trust it.

Parameters:
- COUNT_WIDTH, 4, width of window/strobe counters; requires 1 <= ADD_NUM <= MAX_NUM < 2^COUNT_WIDTH.
- ADD_NUM, 4'd3, expected strobes per window.
- MAX_NUM, 4'd5, window length in clocks.
- LOCK_WINDOWS, 4, consecutive good windows required to declare lock (>= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  strobe under test, sampled every clk.
- clr  in  1  synchronous: clears err_count and forces state SEARCH.
- locked  out  1  stream qualified.
- err  out  1  one-cycle pulse per detected violation.
- err_count  out  8  saturating violation count.
- last_cnt  out  COUNT_WIDTH  strobe count of the most recently completed window.

Behaviour:
- Constants: GMIN = MAX_NUM/ADD_NUM (floor); GMAX = ceil(MAX_NUM/ADD_NUM). Both are elaborated from parameters.
- Reset (rst low, async): state=SEARCH; locked=0, err=0, err_count=0, last_cnt=0; all internal counters 0.
- States:
  - SEARCH: waits for the first `enable`=1.
  - TRACK: aligned, accumulating good windows.
  - LOCKED.
- Alignment: the cycle with the first enable in SEARCH is window position 0, and that strobe counts toward the window. State goes to TRACK.
- Window: position wpos runs 0..MAX_NUM-1 and wraps to 0. Strobe count wcnt includes the current cycle's enable.
- At wpos = MAX_NUM-1:
  - last_cnt <= final wcnt.
  - Window is good iff final wcnt == ADD_NUM.
- Gap: dist = clocks since the previous strobe. It is COUNT_WIDTH+1 bits and saturates.
  - On a strobe with dist < GMIN: violation.
  - If dist reaches GMAX+1 with no strobe: violation (timeout). This is flagged on that cycle, not at the next strobe.
- Good-window counter:
  - Increments per good window in TRACK.
  - Reaching LOCK_WINDOWS moves TRACK -> LOCKED.
- Any violation in TRACK or LOCKED:
  - err=1 on the following cycle only.
  - err_count +1, saturating at 255.
  - State -> SEARCH; good-window counter 0.
  - A strobe on the violating cycle is not used for realignment.
- Simultaneous gap and window violation on one cycle: a single err pulse and a single increment.
- No checks run in SEARCH. A stuck-low enable never raises err.
- locked: registered, equals (state==LOCKED). It drops the cycle after a violation, together with err.
- clr:
  - err_count <= 0; state -> SEARCH; locked -> 0 next cycle.
  - Overrides a coincident violation: no err pulse, count stays 0.
- Async reset mid-operation: all outputs go to reset values immediately, with no glitch-dependent state retained.
- Degenerate case ADD_NUM == MAX_NUM: GMIN = GMAX = 1. A constant-high enable is the only legal stream.

Test Plan:
- Defaults: after reset, drive the repeating pattern 1,0,1,1,0 with the first strobe at cycle t0 -> locked=1 from t0+20, err never asserted, last_cnt=3.
- Locked stream, then suppress one strobe (1,0,0,1,...) -> timeout at dist=3 -> err pulse for exactly one cycle, err_count=1, locked=0. Relock 20 cycles after the next strobe.
- Constant-high enable -> gap OK, first window count 5 != 3 -> err at t0+5, err_count=1. Realign and repeat; err_count keeps rising and saturates at 255 after long runs.
- enable held 0 for 100 cycles after reset -> locked=0, err=0, err_count=0.
- Force a violation on the same cycle clr=1 -> no err pulse, err_count=0, state SEARCH. A subsequent good stream locks 20 cycles after its first strobe.
- Pull rst low while locked with err_count=2 -> locked, err, err_count, last_cnt read 0 before the next clk edge. Recovery after release matches scenario 1.
- Override ADD_NUM=MAX_NUM=5 with constant-high enable -> locked after 20 cycles. A single low cycle -> err pulse.
